// File: rtl/fifo_sync_if.sv
// Handshake and status bundle between the FIFO and its producer/consumer.
interface fifo_sync_if #(
    parameter int unsigned SIZE_DATA  = 8,
    parameter int unsigned SIZE_DEPTH = 8
);
    localparam int unsigned ADDR_WIDTH = $clog2(SIZE_DEPTH);

    logic                  i_wr_en;
    logic                  i_rd_en;
    logic [SIZE_DATA-1:0]  i_data;
    logic [SIZE_DATA-1:0]  o_data;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    // FIFO side
    modport slave (
        input  i_wr_en, i_rd_en, i_data,
        output o_data, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    // Producer/consumer side
    modport master (
        output i_wr_en, i_rd_en, i_data,
        input  o_data, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read port, occupancy count and error pulses.
module fifo_sync #(
    parameter int unsigned SIZE_DATA       = 8,
    parameter int unsigned SIZE_DEPTH      = 8,
    parameter int unsigned ALMOST_FULL_TH  = SIZE_DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_TH = 1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    fifo_sync_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(SIZE_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];
    logic [ADDR_WIDTH:0]  wr_ptr;
    logic [ADDR_WIDTH:0]  rd_ptr;
    logic [ADDR_WIDTH:0]  count;
    logic [SIZE_DATA-1:0] rd_data;
    logic                 overflow;
    logic                 underflow;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;

    // Pointer-derived flags: MSB is the wrap bit, lower bits address memory
    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        rd_acc = bus.i_rd_en & ~empty;
        // A read on the same edge frees a slot, so a full FIFO still takes the write
        wr_acc = bus.i_wr_en & (~full | rd_acc);
    end

    // Storage write; contents are not reset
    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.i_data;
        end
    end

    // Pointers, count, registered read data and error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            overflow  <= bus.i_wr_en & ~wr_acc;
            underflow <= bus.i_rd_en & empty;
        end
    end

    // Status outputs
    always_comb begin
        bus.o_data         = rd_data;
        bus.o_full         = full;
        bus.o_empty        = empty;
        bus.o_almost_full  = (count >= AF_TH);
        bus.o_almost_empty = (count <= AE_TH);
        bus.o_count        = count;
        bus.o_overflow     = overflow;
        bus.o_underflow    = underflow;
    end
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: vector table plus hand-written corner sequences.
module tb_fifo_sync;
    logic i_clk;
    logic i_rst;

    fifo_sync_if #(.SIZE_DATA(8), .SIZE_DEPTH(8)) bus ();

    fifo_sync #(
        .SIZE_DATA      (8),
        .SIZE_DEPTH     (8),
        .ALMOST_FULL_TH (7),
        .ALMOST_EMPTY_TH(1)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];
    int   tests;
    int   fails;

    function automatic vec_t mk(logic wr, logic rd, logic [7:0] din, logic [7:0] dout,
                                logic [3:0] cnt, logic ov, logic un);
        vec_t v;
        v.wr    = wr;
        v.rd    = rd;
        v.din   = din;
        v.dout  = dout;
        v.cnt   = cnt;
        v.full  = (cnt == 4'd8);
        v.empty = (cnt == 4'd0);
        v.af    = (cnt >= 4'd7);
        v.ae    = (cnt <= 4'd1);
        v.ov    = ov;
        v.un    = un;
        return v;
    endfunction

    function automatic logic [17:0] pack_exp(vec_t v);
        return {v.dout, v.cnt, v.full, v.empty, v.af, v.ae, v.ov, v.un};
    endfunction

    function automatic logic [17:0] pack_act();
        return {bus.o_data, bus.o_count, bus.o_full, bus.o_empty, bus.o_almost_full,
                bus.o_almost_empty, bus.o_overflow, bus.o_underflow};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, sample 1 time unit after the edge
    task automatic step(logic wr, logic rd, logic [7:0] din);
        bus.i_wr_en = wr;
        bus.i_rd_en = rd;
        bus.i_data  = din;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.i_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_data  = 8'h00;
        i_rst = 1'b1;

        // Reset held with write traffic: everything ignored
        step(1'b1, 1'b0, 8'h29);
        step(1'b1, 1'b0, 8'h29);
        check("reset_hold", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'h00, 4'd0, 0, 0))));
        i_rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        check("reset_read", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'h00, 4'd0, 0, 1))));

        // Fill: 9 writes, 9th dropped with overflow
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1, 0, 8'(8'hC0 + k), 8'h00, 4'(k), 0, (k == 1)));
        end
        vecs[0].un = 1'b0;
        vecs.push_back(mk(1, 0, 8'hC9, 8'h00, 4'd8, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 4'd8, 0, 0));
        // Drain: 8 reads in order, then read on empty
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(0, 1, 8'h00, 8'(8'hC0 + k), 4'(8 - k), 0, 0));
        end
        vecs.push_back(mk(0, 1, 8'h00, 8'hC8, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'hC8, 4'd0, 0, 0));
        // Concurrent traffic from empty
        vecs.push_back(mk(1, 0, 8'h29, 8'hC8, 4'd1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h30, 8'h29, 4'd1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h31, 8'h30, 4'd1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h31, 4'd0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h31, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h31, 4'd0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check($sformatf("vec%0d", i), 32'(pack_act()), 32'(pack_exp(vecs[i])));
        end

        // Fill then full-concurrent traffic across pointer wrap
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 8'(8'h40 + k));
        end
        check("wrap_filled", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'h31, 4'd8, 0, 0))));
        for (int j = 0; j < 12; j++) begin
            step(1'b1, 1'b1, 8'(8'h48 + j));
            check($sformatf("wrap_rw%0d", j), 32'(pack_act()),
                  32'(pack_exp(mk(0, 0, 0, 8'(8'h40 + j), 4'd8, 0, 0))));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap_drain%0d", k), 32'(pack_act()),
                  32'(pack_exp(mk(0, 0, 0, 8'(8'h4C + k), 4'(7 - k), 0, 0))));
        end

        // Mid-operation asynchronous reset between clock edges
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 8'(8'h60 + k));
        end
        bus.i_wr_en = 1'b0;
        check("pre_reset_cnt", 32'(bus.o_count), 32'd5);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_reset", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'h00, 4'd0, 0, 0))));
        #1;
        i_rst = 1'b0;
        step(1'b1, 1'b0, 8'hA5);
        check("post_reset_wr", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'h00, 4'd1, 0, 0))));
        step(1'b0, 1'b1, 8'h00);
        check("post_reset_rd", 32'(pack_act()), 32'(pack_exp(mk(0, 0, 0, 8'hA5, 4'd0, 0, 0))));
        step(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
